// File: rtl/spi_shift_reg_if.sv
// spi_shift_reg_if: control, data and status bundle between the SPI shift register and its host
interface spi_shift_reg_if #(parameter int WIDTH = 8);
  logic             LOAD;
  logic             START;
  logic             MSB_FIRST;
  logic             SHIFT_EN;
  logic             SDI;
  logic             SDO;
  logic             BUSY;
  logic             DONE;
  logic [WIDTH-1:0] DATA_IN;
  logic [WIDTH-1:0] Q;
  modport master (output LOAD, DATA_IN, START, MSB_FIRST, SHIFT_EN, SDI, input SDO, Q, BUSY, DONE);
  modport slave (input LOAD, DATA_IN, START, MSB_FIRST, SHIFT_EN, SDI, output SDO, Q, BUSY, DONE);
endinterface

// File: rtl/spi_shift_reg.sv
// spi_shift_reg: WIDTH-bit serial/parallel shift register with a tick-driven transfer controller
module spi_shift_reg #(
  parameter int WIDTH = 8
) (
  input logic            CLK,
  input logic            CLR,
  spi_shift_reg_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic             done_q, done_d;
  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_q <= IDLE;
      q_q     <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
    end
  end
  // LOAD and START act together in IDLE so a transfer can shift freshly loaded data
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    done_d  = 1'b0;
    if (state_q == IDLE) begin
      if (bus.LOAD) q_d = bus.DATA_IN;
      if (bus.START) begin
        dir_d   = bus.MSB_FIRST;
        cnt_d   = '0;
        state_d = SHIFT;
      end
    end else if (bus.SHIFT_EN) begin
      q_d   = dir_q ? {q_q[WIDTH-2:0], bus.SDI} : {bus.SDI, q_q[WIDTH-1:1]};
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CW'(WIDTH - 1)) begin
        cnt_d   = '0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
    end
  end
  always_comb begin
    bus.BUSY = state_q == SHIFT;
    bus.DONE = done_q;
    bus.Q    = q_q;
    bus.SDO  = dir_q ? q_q[WIDTH-1] : q_q[0];
  end
endmodule

// File: tb/tb_spi_shift_reg.sv
// tb_spi_shift_reg: randomized scenario bench for spi_shift_reg against a word-level reference model
module tb_spi_shift_reg;
  localparam int W = 8;
  logic CLK = 1'b0;
  logic CLR;
  int   errors = 0;
  int   checks = 0;
  logic [7:0] mq;
  logic       mdir, mdone;
  int         mleft;
  always #5 CLK = ~CLK;
  spi_shift_reg_if #(.WIDTH(W)) bus ();
  spi_shift_reg #(.WIDTH(W)) dut (.CLK(CLK), .CLR(CLR), .bus(bus));

  function automatic logic msdo();
    return mdir ? mq[7] : mq[0];
  endfunction

  task automatic idle();
    bus.LOAD = 0; bus.START = 0; bus.MSB_FIRST = 0; bus.SHIFT_EN = 0; bus.SDI = 0; bus.DATA_IN = 0; CLR = 0;
  endtask

  // advance one edge; the model treats a transfer as "ticks remaining" on a plain integer word
  task automatic cycle();
    @(posedge CLK);
    if (CLR) begin
      mq = 0; mdir = 1; mleft = 0; mdone = 0;
    end else begin
      mdone = 0;
      if (mleft == 0) begin
        if (bus.LOAD) mq = bus.DATA_IN;
        if (bus.START) begin mdir = bus.MSB_FIRST; mleft = W; end
      end else if (bus.SHIFT_EN) begin
        mq = mdir ? 8'((int'(mq) * 2 + int'(bus.SDI)) % 256) : 8'(int'(mq) / 2 + int'(bus.SDI) * 128);
        mleft--;
        if (mleft == 0) mdone = 1;
      end
    end
    #1;
  endtask

  task automatic xfer(input logic [7:0] data, input bit do_load, input bit together, input bit tick_in_start,
                      input logic msb, input logic [7:0] sdi_word, input int period, input bit noise,
                      output logic [7:0] sdo_seq, output int done_at, output bit busy1, output bit model_ok);
    int k;
    bit t;
    k = 0; model_ok = 1; done_at = -1; sdo_seq = 0;
    if (do_load && !together) begin
      bus.LOAD = 1; bus.DATA_IN = data; cycle(); bus.LOAD = 0;
    end
    bus.LOAD = do_load && together; bus.DATA_IN = data; bus.START = 1; bus.MSB_FIRST = msb;
    bus.SHIFT_EN = tick_in_start; bus.SDI = 1'($urandom);
    cycle();
    busy1 = bus.BUSY;
    for (int c = 0; c < period * W + 4; c++) begin
      t = (c % period) == period - 1;
      bus.SHIFT_EN = t;
      bus.SDI = (t && k < W) ? (msb ? sdi_word[7-k] : sdi_word[k]) : 1'($urandom);
      bus.LOAD = noise & 1'($urandom); bus.START = noise & 1'($urandom);
      bus.MSB_FIRST = 1'($urandom); bus.DATA_IN = 8'($urandom);
      if (t && k < W) sdo_seq[7-k] = bus.SDO;
      if (t) k++;
      cycle();
      if (bus.Q !== mq || bus.SDO !== msdo() || bus.BUSY !== (mleft != 0) || bus.DONE !== mdone) model_ok = 0;
      if (bus.DONE === 1'b1) begin done_at = c + 1; break; end
    end
    idle();
  endtask

  task automatic test_reset();
    CLR = 1;
    repeat (2) begin
      bus.LOAD = 1'($urandom); bus.START = 1'($urandom); bus.MSB_FIRST = 1'($urandom);
      bus.SHIFT_EN = 1'($urandom); bus.SDI = 1'($urandom); bus.DATA_IN = 8'($urandom);
      cycle();
    end
    checks += 4;
    if (bus.Q !== 8'h00) begin errors++; $display("FAIL reset_q: got %h want 00", bus.Q); end
    if (bus.BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.BUSY); end
    if (bus.DONE !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.DONE); end
    if (bus.SDO !== 1'b0) begin errors++; $display("FAIL reset_sdo: got %b want 0", bus.SDO); end
    idle();
    cycle();
  endtask

  task automatic test_msb_first();
    logic [7:0] s; int d; bit b1, ok;
    xfer(8'hA5, 1, 0, 0, 1, 8'h3C, 1, 0, s, d, b1, ok);
    checks += 7;
    if (s !== 8'hA5) begin errors++; $display("FAIL msb_sdo_seq: got %b want 10100101", s); end
    if (bus.Q !== 8'h3C) begin errors++; $display("FAIL msb_q: got %h want 3c", bus.Q); end
    if (d !== 8) begin errors++; $display("FAIL msb_latency: got %0d want 8", d); end
    if (bus.BUSY !== 1'b0) begin errors++; $display("FAIL msb_busy_drop: got %b want 0", bus.BUSY); end
    if (bus.DONE !== 1'b1) begin errors++; $display("FAIL msb_done: got %b want 1", bus.DONE); end
    if (b1 !== 1'b1) begin errors++; $display("FAIL msb_busy_start: got %b want 1", b1); end
    if (ok !== 1'b1) begin errors++; $display("FAIL msb_model: got %b want 1", ok); end
    cycle();
    checks += 2;
    if (bus.DONE !== 1'b0) begin errors++; $display("FAIL msb_done_pulse: got %b want 0", bus.DONE); end
    if (bus.Q !== 8'h3C) begin errors++; $display("FAIL msb_q_hold: got %h want 3c", bus.Q); end
  endtask

  task automatic test_lsb_first();
    logic [7:0] s; int d; bit b1, ok;
    xfer(8'h01, 1, 0, 0, 0, 8'hFF, 1, 0, s, d, b1, ok);
    checks += 4;
    if (s !== 8'h80) begin errors++; $display("FAIL lsb_sdo_seq: got %b want 10000000", s); end
    if (bus.Q !== 8'hFF) begin errors++; $display("FAIL lsb_q: got %h want ff", bus.Q); end
    if (d !== 8) begin errors++; $display("FAIL lsb_latency: got %0d want 8", d); end
    if (ok !== 1'b1) begin errors++; $display("FAIL lsb_model: got %b want 1", ok); end
    cycle();
  endtask

  task automatic test_gapped();
    logic [7:0] s; int d; bit b1, ok;
    xfer(8'h5A, 1, 0, 0, 1, 8'h00, 3, 1, s, d, b1, ok);
    checks += 4;
    if (d !== 24) begin errors++; $display("FAIL gap_latency: got %0d want 24", d); end
    if (bus.Q !== 8'h00) begin errors++; $display("FAIL gap_q: got %h want 00", bus.Q); end
    if (s !== 8'h5A) begin errors++; $display("FAIL gap_sdo_seq: got %b want 01011010", s); end
    if (ok !== 1'b1) begin errors++; $display("FAIL gap_model: got %b want 1", ok); end
    cycle();
  endtask

  task automatic test_protect_abort();
    logic [7:0] s; int d; bit b1, ok;
    bus.LOAD = 1; bus.DATA_IN = 8'h96; cycle();
    bus.LOAD = 0; bus.START = 1; bus.MSB_FIRST = 1; cycle();
    bus.START = 0;
    repeat (2) begin bus.SHIFT_EN = 1; bus.SDI = 1; cycle(); end
    bus.SHIFT_EN = 0; bus.LOAD = 1; bus.DATA_IN = 8'hFF; bus.START = 1; bus.MSB_FIRST = 0;
    cycle();
    idle();
    checks += 4;
    if (bus.Q !== 8'h5B) begin errors++; $display("FAIL prot_q: got %h want 5b", bus.Q); end
    if (bus.BUSY !== 1'b1) begin errors++; $display("FAIL prot_busy: got %b want 1", bus.BUSY); end
    if (bus.SDO !== 1'b0) begin errors++; $display("FAIL prot_dir: got %b want 0", bus.SDO); end
    if (bus.Q !== mq) begin errors++; $display("FAIL prot_model: got %h want %h", bus.Q, mq); end
    repeat (2) begin bus.SHIFT_EN = 1; bus.SDI = 0; cycle(); end
    checks += 1;
    if (bus.Q !== 8'h6C) begin errors++; $display("FAIL prot_q4: got %h want 6c", bus.Q); end
    CLR = 1; bus.LOAD = 1; bus.START = 1; bus.SHIFT_EN = 1; bus.DATA_IN = 8'($urandom); bus.SDI = 1;
    cycle();
    idle();
    checks += 4;
    if (bus.Q !== 8'h00) begin errors++; $display("FAIL abort_q: got %h want 00", bus.Q); end
    if (bus.BUSY !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", bus.BUSY); end
    if (bus.DONE !== 1'b0) begin errors++; $display("FAIL abort_done: got %b want 0", bus.DONE); end
    if (bus.SDO !== 1'b0) begin errors++; $display("FAIL abort_sdo: got %b want 0", bus.SDO); end
    bus.SHIFT_EN = 1; cycle(); bus.SHIFT_EN = 0;
    checks += 2;
    if (bus.DONE !== 1'b0) begin errors++; $display("FAIL abort_no_done: got %b want 0", bus.DONE); end
    if (bus.Q !== 8'h00) begin errors++; $display("FAIL abort_idle_shift: got %h want 00", bus.Q); end
    xfer(8'hC3, 1, 0, 0, 1, 8'h0F, 1, 0, s, d, b1, ok);
    checks += 3;
    if (s !== 8'hC3) begin errors++; $display("FAIL post_abort_sdo: got %b want 11000011", s); end
    if (bus.Q !== 8'h0F) begin errors++; $display("FAIL post_abort_q: got %h want 0f", bus.Q); end
    if (d !== 8) begin errors++; $display("FAIL post_abort_latency: got %0d want 8", d); end
    cycle();
  endtask

  task automatic test_same_cycle();
    logic [7:0] s, w; int d; bit b1, ok;
    xfer(8'h81, 1, 1, 0, 1, 8'h66, 1, 0, s, d, b1, ok);
    checks += 3;
    if (s !== 8'h81) begin errors++; $display("FAIL ls_sdo_seq: got %b want 10000001", s); end
    if (bus.Q !== 8'h66) begin errors++; $display("FAIL ls_q: got %h want 66", bus.Q); end
    if (ok !== 1'b1) begin errors++; $display("FAIL ls_model: got %b want 1", ok); end
    cycle();
    w = 8'($urandom);
    xfer(w, 1, 0, 1, 0, 8'h9E, 1, 0, s, d, b1, ok);
    checks += 3;
    if (d !== 8) begin errors++; $display("FAIL tick_in_start_latency: got %0d want 8", d); end
    if (bus.Q !== 8'h9E) begin errors++; $display("FAIL tick_in_start_q: got %h want 9e", bus.Q); end
    if (ok !== 1'b1) begin errors++; $display("FAIL tick_in_start_model: got %b want 1", ok); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] s, a, b; int d; bit b1, ok;
    a = 8'($urandom); b = 8'($urandom);
    xfer(a, 1, 0, 0, 1, b, 1, 0, s, d, b1, ok);
    checks += 2;
    if (bus.DONE !== 1'b1) begin errors++; $display("FAIL b2b_first_done: got %b want 1", bus.DONE); end
    if (bus.Q !== b) begin errors++; $display("FAIL b2b_first_q: got %h want %h", bus.Q, b); end
    xfer(8'h00, 0, 0, 0, 0, a, 1, 0, s, d, b1, ok);
    checks += 5;
    if (b1 !== 1'b1) begin errors++; $display("FAIL b2b_busy: got %b want 1", b1); end
    if (d !== 8) begin errors++; $display("FAIL b2b_latency: got %0d want 8", d); end
    if (s !== {b[0], b[1], b[2], b[3], b[4], b[5], b[6], b[7]}) begin
      errors++; $display("FAIL b2b_sdo_seq: got %b want bits of %h lsb first", s, b);
    end
    if (bus.Q !== a) begin errors++; $display("FAIL b2b_q: got %h want %h", bus.Q, a); end
    if (ok !== 1'b1) begin errors++; $display("FAIL b2b_model: got %b want 1", ok); end
    cycle();
  endtask

  initial begin
    mq = 0; mdir = 1; mleft = 0; mdone = 0;
    idle();
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_gapped();
    test_protect_abort();
    test_same_cycle();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
